// File: rtl/issue_queue.sv
// issue_queue: DEPTH-entry instruction buffer between an issuer and decode.
// Both sides use a toggle/level handshake whose inputs are synchronised into
// the clk domain. Supports flush (branch redirect) and reports occupancy.
//
// Ports:
//   clk        - clock, all state updates on rising edge
//   reset      - asynchronous, active-high reset
//   dataIn     - word from issuer, stable while readyIn is high
//   readyIn    - issuer word valid (level, return-to-zero, asynchronous)
//   triggerOut - request to issuer, each toggle asks for one word
//   dataOut    - head entry to decode
//   readyOut   - head valid to decode
//   triggerIn  - decode pop, each toggle consumes the head (asynchronous)
//   flush      - synchronous one-cycle pulse, empties the queue
//   count      - occupancy, 0..DEPTH
module issue_queue #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned ADDR_W      = 2,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] dataIn,
   input  logic                  readyIn,
   output logic                  triggerOut,
   output logic [DATA_WIDTH-1:0] dataOut,
   output logic                  readyOut,
   input  logic                  triggerIn,
   input  logic                  flush,
   output logic [ADDR_W:0]       count
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_LO,
      WAIT_HI
   } up_state_t;

   localparam logic [ADDR_W:0]   FULL     = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   up_state_t               state;
   logic [SYNC_STAGES-1:0]  rdy_sync;
   logic [SYNC_STAGES-1:0]  trg_sync;
   logic                    rdy_s;
   logic                    trg_s;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic [ADDR_W-1:0]       wr_ptr;
   logic [ADDR_W-1:0]       rd_ptr;
   logic                    trig_phase;
   logic                    drop_next;

   logic                    arrive;
   logic                    capture;
   logic                    pop;
   logic [ADDR_W:0]         cnt_nxt;

   assign rdy_s = rdy_sync[SYNC_STAGES-1];
   assign trg_s = trg_sync[SYNC_STAGES-1];

   // readyOut uses raw triggerIn so it drops the same cycle decode toggles.
   assign readyOut = (count != '0) && (triggerIn == trig_phase);
   assign dataOut  = mem[rd_ptr];

   always_comb begin
      arrive  = (state == WAIT_HI) && rdy_s;
      // An arriving word answering a pre-flush request is discarded, and
      // flush itself wins over any same-cycle capture or pop.
      capture = arrive && !drop_next && !flush;
      pop     = (trg_s != trig_phase) && (count != '0) && !flush;
      cnt_nxt = count;
      if (flush) begin
         cnt_nxt = '0;
      end else begin
         case ({capture, pop})
            2'b10:   cnt_nxt = count + CNT_ONE;
            2'b01:   cnt_nxt = count - CNT_ONE;
            default: cnt_nxt = count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdy_sync   <= '0;
         trg_sync   <= '0;
         state      <= WAIT_HI;
         triggerOut <= 1'b0;
         trig_phase <= 1'b0;
         drop_next  <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i[ADDR_W-1:0]] <= '0;
         end
      end else begin
         rdy_sync <= {rdy_sync[SYNC_STAGES-2:0], readyIn};
         trg_sync <= {trg_sync[SYNC_STAGES-2:0], triggerIn};
         count    <= cnt_nxt;

         if (capture) begin
            mem[wr_ptr] <= dataIn;
            wr_ptr      <= wr_ptr + PTR_ONE;
         end

         if (flush) begin
            rd_ptr     <= wr_ptr;
            trig_phase <= trg_s;
         end else if (pop) begin
            rd_ptr     <= rd_ptr + PTR_ONE;
            trig_phase <= trg_s;
         end

         // A request outstanding at flush time answers with stale data.
         if (flush && (state != IDLE)) begin
            drop_next <= 1'b1;
         end else if (arrive && drop_next) begin
            drop_next <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (count != FULL) begin
                  triggerOut <= ~triggerOut;
                  state      <= WAIT_LO;
               end
            end
            WAIT_LO: begin
               if (!rdy_s) begin
                  state <= WAIT_HI;
               end
            end
            WAIT_HI: begin
               if (rdy_s) begin
                  if (cnt_nxt != FULL) begin
                     triggerOut <= ~triggerOut;
                     state      <= WAIT_LO;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= WAIT_HI;
         endcase
      end
   end

endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: randomized issuer/decode/flush stimulus for issue_queue,
// checked every cycle against a transaction-level queue model.
module tb_issue_queue;

   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 2;
   localparam int unsigned SS    = 2;
   localparam int unsigned NCYC  = 4000;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [DW-1:0] dataIn;
   logic          readyIn;
   logic          triggerOut;
   logic [DW-1:0] dataOut;
   logic          readyOut;
   logic          triggerIn;
   logic          flush;
   logic [AW:0]   count;

   always #5 clk = ~clk;

   issue_queue #(
      .DATA_WIDTH(DW),
      .DEPTH(DEPTH),
      .ADDR_W(AW),
      .SYNC_STAGES(SS)
   ) dut (
      .clk(clk),
      .reset(reset),
      .dataIn(dataIn),
      .readyIn(readyIn),
      .triggerOut(triggerOut),
      .dataOut(dataOut),
      .readyOut(readyOut),
      .triggerIn(triggerIn),
      .flush(flush),
      .count(count)
   );

   int unsigned total = 0;
   int unsigned bad   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [DW-1:0] words[$];      // buffered words, head at index 0
   bit            rdy_pipe[$];   // readyIn as seen through the synchroniser
   bit            trg_pipe[$];   // triggerIn as seen through the synchroniser
   bit            m_req;         // a request to the issuer is outstanding
   bit            m_armed;       // issuer has been seen low since that request
   bit            m_drop;        // next delivered word is stale
   bit            m_phase;       // last decode toggle level already honoured
   bit            m_tog;         // expected triggerOut level

   task automatic model_reset();
      words.delete();
      rdy_pipe.delete();
      trg_pipe.delete();
      for (int i = 0; i < int'(SS); i++) begin
         rdy_pipe.push_back(1'b0);
         trg_pipe.push_back(1'b0);
      end
      m_req   = 1'b1;   // the first word needs no request
      m_armed = 1'b1;
      m_drop  = 1'b0;
      m_phase = 1'b0;
      m_tog   = 1'b0;
   endtask

   task automatic issue_request();
      m_req   = 1'b1;
      m_armed = 1'b0;
      m_tog   = ~m_tog;
   endtask

   task automatic model_step();
      bit rdy_s, trg_s, got_word, do_pop, was_req;
      int old_size;
      rdy_s = rdy_pipe.pop_front();
      rdy_pipe.push_back(readyIn);
      trg_s = trg_pipe.pop_front();
      trg_pipe.push_back(triggerIn);

      old_size = words.size();
      was_req  = m_req;
      got_word = m_req && m_armed && rdy_s;
      do_pop   = (trg_s != m_phase) && (old_size > 0);
      if (m_req && !m_armed && !rdy_s) m_armed = 1'b1;

      if (got_word) begin
         m_req = 1'b0;
         if (!flush) begin
            if (m_drop) m_drop = 1'b0;
            else words.push_back(dataIn);
         end
      end
      if (flush) begin
         words.delete();
         m_phase = trg_s;
         if (was_req) m_drop = 1'b1;
      end else if (do_pop) begin
         void'(words.pop_front());
         m_phase = trg_s;
      end

      if (got_word) begin
         if (words.size() < int'(DEPTH)) issue_request();
      end else if (!was_req && old_size < int'(DEPTH)) begin
         issue_request();
      end
   endtask

   task automatic check_outputs();
      bit exp_rdy;
      exp_rdy = (words.size() != 0) && (triggerIn == m_phase);
      check_eq("count", 64'(count), 64'(words.size()));
      check_eq("readyOut", 64'(readyOut), 64'(exp_rdy));
      check_eq("triggerOut", 64'(triggerOut), 64'(m_tog));
      if (exp_rdy) check_eq("dataOut", 64'(dataOut), 64'(words[0]));
   endtask

   // ---------------- stimulus ----------------
   typedef enum {I_WAIT, I_DELAY, I_HOLD, I_GAP} iss_t;
   iss_t        iss;
   int unsigned iss_cnt;
   bit          req_pend;
   bit          last_trig;

   task automatic issuer_reset();
      readyIn   = 1'b0;
      iss       = I_WAIT;
      iss_cnt   = 0;
      req_pend  = 1'b1;
      last_trig = 1'b0;
   endtask

   task automatic drive_issuer();
      if (triggerOut != last_trig) begin
         last_trig = triggerOut;
         req_pend  = 1'b1;
      end
      case (iss)
         I_WAIT: if (req_pend) begin
            req_pend = 1'b0;
            iss_cnt  = $urandom_range(3);
            iss      = I_DELAY;
         end
         I_DELAY: if (iss_cnt == 0) begin
            readyIn = 1'b1;
            dataIn  = $urandom;
            iss_cnt = $urandom_range(5, 2);
            iss     = I_HOLD;
         end else iss_cnt--;
         I_HOLD: if (iss_cnt == 0) begin
            readyIn = 1'b0;
            iss_cnt = $urandom_range(2);
            iss     = I_GAP;
         end else iss_cnt--;
         I_GAP: if (iss_cnt == 0) iss = I_WAIT; else iss_cnt--;
         default: iss = I_WAIT;
      endcase
   endtask

   task automatic drive_decode(input int unsigned cyc);
      int unsigned pct;
      case ((cyc / 250) % 4)
         0:       pct = 0;
         1:       pct = 15;
         2:       pct = 50;
         default: pct = 100;
      endcase
      // Only toggle once the previous toggle has been honoured.
      if (triggerIn == m_phase) begin
         if (words.size() != 0) begin
            if ($urandom_range(99) < pct) triggerIn = ~triggerIn;
         end else if ($urandom_range(99) < 4) begin
            triggerIn = ~triggerIn;
         end
      end
   endtask

   initial begin
      dataIn    = '0;
      triggerIn = 1'b0;
      flush     = 1'b0;
      issuer_reset();
      model_reset();
      #2;
      check_eq("rst_count", 64'(count), 64'd0);
      check_eq("rst_readyOut", 64'(readyOut), 64'd0);
      check_eq("rst_triggerOut", 64'(triggerOut), 64'd0);
      check_eq("rst_dataOut", 64'(dataOut), 64'd0);

      // Issuer presents its first word straight out of reset.
      @(negedge clk);
      readyIn  = 1'b1;
      dataIn   = 32'hE3A00001;
      iss      = I_HOLD;
      iss_cnt  = 3;
      req_pend = 1'b0;
      reset    = 1'b0;

      for (int unsigned cyc = 0; cyc < NCYC; cyc++) begin
         @(posedge clk);
         if (!reset) model_step();
         #1;
         if (cyc == 2000) begin
            reset = 1'b1;
            flush = 1'b0;
            model_reset();
            issuer_reset();
            #1;
            check_eq("midrst_dataOut", 64'(dataOut), 64'd0);
         end else if (!reset) begin
            drive_issuer();
            drive_decode(cyc);
            flush = ($urandom_range(59) == 0);
         end
         @(negedge clk);
         check_outputs();
         if (cyc == 2001) reset = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
